sdram_frame_scheduler: RTL and testbench

//  Sequences SDRAM burst traffic between the camera write FIFO and the TFT read FIFO.

---
 rtl/sdram_frame_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sdram_frame_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_scheduler.sv
// Triple-buffered frame scheduler: arbitrates camera write bursts and display read bursts
// to the SDRAM command engine, and rotates banks on frame boundaries without tearing.
module sdram_frame_scheduler #(
   parameter int unsigned ADDR_W      = 22,
   parameter int unsigned FIFO_W      = 10,
   parameter int unsigned BURST_LEN   = 16,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter int unsigned RD_DEPTH    = 512,
   parameter int unsigned RD_LOW_WM   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [FIFO_W-1:0] wr_level,
   input  logic              wr_frame_start,
   input  logic [FIFO_W-1:0] rd_level,
   input  logic              rd_frame_start,
   output logic              cmd_valid,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic [1:0]        wr_bank,
   output logic [1:0]        rd_bank,
   output logic              frame_fresh,
   output logic [7:0]        drop_cnt
);

   localparam logic [FIFO_W-1:0] BURST_LVL  = FIFO_W'(BURST_LEN);
   localparam logic [FIFO_W-1:0] RD_MAX_LVL = FIFO_W'(RD_DEPTH - BURST_LEN);
   localparam logic [FIFO_W-1:0] LOW_WM_LVL = FIFO_W'(RD_LOW_WM);
   localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] BURST_OFF  = ADDR_W'(BURST_LEN);

   typedef enum logic [1:0] {StIdle, StArb, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              cmd_write_q, cmd_write_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [1:0]        wr_bank_q, wr_bank_d;
   logic [1:0]        rd_bank_q, rd_bank_d;
   logic [1:0]        ready_bank_q, ready_bank_d;
   logic              frame_fresh_q, frame_fresh_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic [ADDR_W-1:0] wr_off_q, wr_off_d;
   logic [ADDR_W-1:0] rd_off_q, rd_off_d;
   logic              wr_pend_q, wr_pend_d;
   logic              rd_pend_q, rd_pend_d;
   logic              last_write_q, last_write_d;

   logic              wr_elig, rd_elig, rd_urgent, grant_write;

   function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] bank);
      case (bank)
         2'd1:    bank_base = FRAME_END;
         2'd2:    bank_base = FRAME_END + FRAME_END;
         default: bank_base = '0;
      endcase
   endfunction

   assign wr_elig   = (wr_level >= BURST_LVL) && (wr_off_q < FRAME_END);
   assign rd_elig   = (rd_level <= RD_MAX_LVL) && (rd_off_q < FRAME_END);
   assign rd_urgent = rd_elig && (rd_level < LOW_WM_LVL);

   always_comb begin
      state_d       = state_q;
      cmd_valid_d   = cmd_valid_q;
      cmd_write_d   = cmd_write_q;
      cmd_addr_d    = cmd_addr_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      ready_bank_d  = ready_bank_q;
      frame_fresh_d = frame_fresh_q;
      drop_cnt_d    = drop_cnt_q;
      wr_off_d      = wr_off_q;
      rd_off_d      = rd_off_q;
      wr_pend_d     = wr_pend_q | wr_frame_start;
      rd_pend_d     = rd_pend_q | rd_frame_start;
      last_write_d  = last_write_q;
      grant_write   = 1'b0;

      case (state_q)
         StIdle: begin
            // Camera event first, so a coincident display event shows the frame just finished.
            if (wr_pend_q) begin
               if (wr_off_q == FRAME_END) begin
                  ready_bank_d  = wr_bank_q;
                  wr_bank_d     = 2'd3 - wr_bank_q - rd_bank_q;
                  frame_fresh_d = 1'b1;
               end else if (drop_cnt_q != 8'hff) begin
                  drop_cnt_d = drop_cnt_q + 8'd1;
               end
               wr_off_d = '0;
            end
            if (rd_pend_q) begin
               rd_off_d = '0;
               if (frame_fresh_d) begin
                  rd_bank_d     = ready_bank_d;
                  frame_fresh_d = 1'b0;
               end
            end
            wr_pend_d = wr_frame_start;
            rd_pend_d = rd_frame_start;
            state_d   = StArb;
         end
         StArb: begin
            if (!enable || !(wr_elig || rd_elig)) begin
               state_d = StIdle;
            end else begin
               // Urgent read wins; otherwise round-robin when both are eligible.
               grant_write  = !rd_urgent && wr_elig && (!rd_elig || !last_write_q);
               cmd_write_d  = grant_write;
               last_write_d = grant_write;
               cmd_addr_d   = grant_write ? bank_base(wr_bank_q) + wr_off_q
                                          : bank_base(rd_bank_q) + rd_off_q;
               cmd_valid_d  = 1'b1;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (cmd_done) begin
               if (cmd_write_q) wr_off_d = wr_off_q + BURST_OFF;
               else             rd_off_d = rd_off_q + BURST_OFF;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cmd_valid_q   <= 1'b0;
         cmd_write_q   <= 1'b0;
         cmd_addr_q    <= '0;
         wr_bank_q     <= 2'd0;
         rd_bank_q     <= 2'd1;
         ready_bank_q  <= 2'd1;
         frame_fresh_q <= 1'b0;
         drop_cnt_q    <= 8'd0;
         wr_off_q      <= '0;
         rd_off_q      <= '0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         last_write_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_write_q   <= cmd_write_d;
         cmd_addr_q    <= cmd_addr_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         ready_bank_q  <= ready_bank_d;
         frame_fresh_q <= frame_fresh_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_off_q      <= wr_off_d;
         rd_off_q      <= rd_off_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         last_write_q  <= last_write_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_write   = cmd_write_q;
   assign cmd_addr    = cmd_addr_q;
   assign wr_bank     = wr_bank_q;
   assign rd_bank     = rd_bank_q;
   assign frame_fresh = frame_fresh_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Bench for sdram_frame_scheduler: random burst traffic checked against a transaction-level
// model of banks, offsets, grants and frame events. Uses a short frame to keep runs small.
module tb_sdram_frame_scheduler;

   localparam int ADDR_W    = 22;
   localparam int FIFO_W    = 10;
   localparam int BURST_LEN = 16;
   localparam int FW        = 640;
   localparam int RD_DEPTH  = 512;
   localparam int RD_LOW_WM = 64;
   localparam int NBURSTS   = FW / BURST_LEN;

   logic              clk = 1'b0;
   logic              reset, enable;
   logic [FIFO_W-1:0] wr_level, rd_level;
   logic              wr_frame_start, rd_frame_start;
   logic              cmd_valid, cmd_write, cmd_ready, cmd_done;
   logic [ADDR_W-1:0] cmd_addr;
   logic [1:0]        wr_bank, rd_bank;
   logic              frame_fresh;
   logic [7:0]        drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   int m_wr_bank, m_rd_bank, m_ready, m_fresh, m_drop, m_wr_off, m_rd_off, m_last_write;
   logic              last_seen_write;
   logic [ADDR_W-1:0] last_seen_addr;

   always #5 clk = ~clk;

   sdram_frame_scheduler #(
      .ADDR_W     (ADDR_W),
      .FIFO_W     (FIFO_W),
      .BURST_LEN  (BURST_LEN),
      .FRAME_WORDS(FW),
      .RD_DEPTH   (RD_DEPTH),
      .RD_LOW_WM  (RD_LOW_WM)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .wr_level      (wr_level),
      .wr_frame_start(wr_frame_start),
      .rd_level      (rd_level),
      .rd_frame_start(rd_frame_start),
      .cmd_valid     (cmd_valid),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_ready     (cmd_ready),
      .cmd_done      (cmd_done),
      .wr_bank       (wr_bank),
      .rd_bank       (rd_bank),
      .frame_fresh   (frame_fresh),
      .drop_cnt      (drop_cnt)
   );

   function automatic int third_bank(input int a, input int b);
      for (int k = 0; k < 3; k++) if (k != a && k != b) return k;
      return 0;
   endfunction

   task automatic model_init();
      m_wr_bank = 0; m_rd_bank = 1; m_ready = 1; m_fresh = 0; m_drop = 0;
      m_wr_off = 0; m_rd_off = 0; m_last_write = 0;
   endtask

   task automatic model_apply(input bit w, input bit r);
      if (w) begin
         if (m_wr_off == FW) begin
            m_ready   = m_wr_bank;
            m_wr_bank = third_bank(m_wr_bank, m_rd_bank);
            m_fresh   = 1;
         end else if (m_drop < 255) begin
            m_drop++;
         end
         m_wr_off = 0;
      end
      if (r) begin
         m_rd_off = 0;
         if (m_fresh != 0) begin
            m_rd_bank = m_ready;
            m_fresh   = 0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; wr_level = '0; rd_level = 10'd512;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_init();
   endtask

   task automatic pulse_events(input bit w, input bit r);
      wr_frame_start = w; rd_frame_start = r;
      @(negedge clk);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      repeat (4) @(negedge clk);
      model_apply(w, r);
   endtask

   // One transaction: predict the grant from the model, serve it as the engine, update model.
   task automatic do_burst(input int rdly, input int ddly, input bit ev_w, input bit ev_r);
      bit w_el, r_el, urg, gw, seen;
      int waited;
      logic [ADDR_W-1:0] exp_a, a0;
      w_el = (int'(wr_level) >= BURST_LEN) && (m_wr_off < FW);
      r_el = (int'(rd_level) <= RD_DEPTH - BURST_LEN) && (m_rd_off < FW);
      urg  = r_el && (int'(rd_level) < RD_LOW_WM);
      if (!enable || !(w_el || r_el)) begin
         seen = 0;
         repeat (12) begin
            @(negedge clk);
            if (cmd_valid) seen = 1;
         end
         n_checks++;
         if (seen) begin
            n_errors++;
            $display("FAIL no_grant: cmd_valid seen=1 required=0");
         end
         return;
      end
      if (urg) gw = 0;
      else if (w_el && r_el) gw = (m_last_write == 0);
      else gw = w_el;
      exp_a = gw ? ADDR_W'(m_wr_bank * FW + m_wr_off) : ADDR_W'(m_rd_bank * FW + m_rd_off);
      waited = 0;
      while (!cmd_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (cmd_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL grant_timeout: cmd_valid=%b required=1", cmd_valid);
         return;
      end
      n_checks++;
      if (cmd_write !== gw || cmd_addr !== exp_a) begin
         n_errors++;
         $display("FAIL grant: write=%b addr=%0d required write=%b addr=%0d",
                  cmd_write, cmd_addr, gw, exp_a);
      end
      n_checks++;
      if (wr_bank !== 2'(m_wr_bank) || rd_bank !== 2'(m_rd_bank) ||
          frame_fresh !== 1'(m_fresh) || drop_cnt !== 8'(m_drop)) begin
         n_errors++;
         $display("FAIL bank_state: wr=%0d rd=%0d fresh=%b drop=%0d required %0d %0d %0d %0d",
                  wr_bank, rd_bank, frame_fresh, drop_cnt, m_wr_bank, m_rd_bank, m_fresh, m_drop);
      end
      last_seen_write = cmd_write;
      last_seen_addr  = cmd_addr;
      a0 = cmd_addr;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         n_checks++;
         if (cmd_valid !== 1'b1 || cmd_write !== gw || cmd_addr !== a0) begin
            n_errors++;
            $display("FAIL cmd_hold: valid=%b write=%b addr=%0d required 1 %b %0d",
                     cmd_valid, cmd_write, cmd_addr, gw, a0);
         end
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      n_checks++;
      if (cmd_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL valid_drop: cmd_valid=%b required=0", cmd_valid);
      end
      m_last_write = gw ? 1 : 0;
      wr_frame_start = ev_w; rd_frame_start = ev_r;
      @(negedge clk);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      repeat (ddly) @(negedge clk);
      n_checks++;
      if (wr_bank !== 2'(m_wr_bank) || rd_bank !== 2'(m_rd_bank) ||
          frame_fresh !== 1'(m_fresh)) begin
         n_errors++;
         $display("FAIL wait_hold: wr=%0d rd=%0d fresh=%b required %0d %0d %0d",
                  wr_bank, rd_bank, frame_fresh, m_wr_bank, m_rd_bank, m_fresh);
      end
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      if (gw) m_wr_off += BURST_LEN;
      else    m_rd_off += BURST_LEN;
      model_apply(ev_w, ev_r);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== '0) begin
         n_errors++;
         $display("FAIL reset_cmd: valid=%b write=%b addr=%0d required 0 0 0",
                  cmd_valid, cmd_write, cmd_addr);
      end
      n_checks++;
      if (wr_bank !== 2'd0 || rd_bank !== 2'd1 || frame_fresh !== 1'b0 || drop_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_banks: wr=%0d rd=%0d fresh=%b drop=%0d required 0 1 0 0",
                  wr_bank, rd_bank, frame_fresh, drop_cnt);
      end
   endtask

   task automatic test_first_write();
      enable = 1'b1; wr_level = 10'd16; rd_level = 10'd512;
      do_burst(3, 2, 1'b0, 1'b0);
      n_checks++;
      if (last_seen_write !== 1'b1 || last_seen_addr !== '0) begin
         n_errors++;
         $display("FAIL first_write: write=%b addr=%0d required 1 0",
                  last_seen_write, last_seen_addr);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] pat;
      pat = 4'b1010;
      do_reset();
      enable = 1'b1; wr_level = 10'd100; rd_level = 10'd200;
      for (int i = 0; i < 4; i++) begin
         do_burst(0, 1, 1'b0, 1'b0);
         n_checks++;
         if (last_seen_write !== pat[3-i]) begin
            n_errors++;
            $display("FAIL round_robin[%0d]: write=%b required=%b", i, last_seen_write, pat[3-i]);
         end
      end
      do_burst(0, 1, 1'b0, 1'b0);
      rd_level = 10'd10;
      do_burst(1, 0, 1'b0, 1'b0);
      n_checks++;
      if (last_seen_write !== 1'b0) begin
         n_errors++;
         $display("FAIL urgent_read: write=%b required=0", last_seen_write);
      end
   endtask

   task automatic test_random();
      int wl[4];
      int rl[8];
      wl = '{0, 8, 16, 300};
      rl = '{0, 40, 63, 64, 200, 496, 497, 512};
      for (int n = 0; n < 120; n++) begin
         enable   = ($urandom_range(0, 9) != 0);
         wr_level = FIFO_W'(wl[$urandom_range(0, 3)]);
         rd_level = FIFO_W'(rl[$urandom_range(0, 7)]);
         do_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic test_full_frame();
      do_reset();
      enable = 1'b1; wr_level = 10'd16; rd_level = 10'd512;
      for (int i = 0; i < NBURSTS; i++)
         do_burst(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      do_burst(0, 0, 1'b0, 1'b0);
      wr_level = '0;
      pulse_events(1'b1, 1'b0);
      n_checks++;
      if (wr_bank !== 2'd2 || frame_fresh !== 1'b1) begin
         n_errors++;
         $display("FAIL frame_done: wr=%0d fresh=%b required 2 1", wr_bank, frame_fresh);
      end
      pulse_events(1'b0, 1'b1);
      n_checks++;
      if (rd_bank !== 2'd0 || frame_fresh !== 1'b0) begin
         n_errors++;
         $display("FAIL frame_show: rd=%0d fresh=%b required 0 0", rd_bank, frame_fresh);
      end
      rd_level = 10'd200;
      do_burst(1, 1, 1'b0, 1'b0);
      n_checks++;
      if (last_seen_write !== 1'b0 || last_seen_addr !== '0) begin
         n_errors++;
         $display("FAIL new_frame_read: write=%b addr=%0d required 0 0",
                  last_seen_write, last_seen_addr);
      end
   endtask

   task automatic test_drop();
      do_reset();
      enable = 1'b1; wr_level = 10'd16; rd_level = 10'd512;
      for (int i = 0; i < 10; i++) do_burst(0, 1, 1'b0, 1'b0);
      wr_level = '0;
      pulse_events(1'b1, 1'b0);
      n_checks++;
      if (drop_cnt !== 8'd1 || wr_bank !== 2'd0 || frame_fresh !== 1'b0) begin
         n_errors++;
         $display("FAIL drop: drop=%0d wr=%0d fresh=%b required 1 0 0",
                  drop_cnt, wr_bank, frame_fresh);
      end
      wr_level = 10'd16;
      do_burst(0, 1, 1'b0, 1'b0);
      n_checks++;
      if (last_seen_write !== 1'b1 || last_seen_addr !== '0) begin
         n_errors++;
         $display("FAIL drop_restart: write=%b addr=%0d required 1 0",
                  last_seen_write, last_seen_addr);
      end
   endtask

   task automatic test_events_in_wait();
      do_reset();
      enable = 1'b1; wr_level = 10'd16; rd_level = 10'd512;
      for (int i = 0; i < NBURSTS - 1; i++) do_burst(0, 0, 1'b0, 1'b0);
      do_burst(1, 3, 1'b1, 1'b1);
      wr_level = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (wr_bank !== 2'd2 || rd_bank !== 2'd0 || frame_fresh !== 1'b0) begin
         n_errors++;
         $display("FAIL both_events: wr=%0d rd=%0d fresh=%b required 2 0 0",
                  wr_bank, rd_bank, frame_fresh);
      end
      rd_level = 10'd300;
      do_burst(0, 1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_in_wait();
      int waited;
      do_reset();
      enable = 1'b1; wr_level = 10'd16; rd_level = 10'd512;
      for (int i = 0; i < 3; i++) do_burst(0, 0, 1'b0, 1'b0);
      wr_level = '0;
      pulse_events(1'b1, 1'b0);
      wr_level = 10'd16;
      for (int i = 0; i < 2; i++) do_burst(0, 0, 1'b0, 1'b0);
      waited = 0;
      while (!cmd_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      wr_level = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== '0 || wr_bank !== 2'd0 ||
          rd_bank !== 2'd1 || frame_fresh !== 1'b0 || drop_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_in_wait: v=%b w=%b a=%0d wb=%0d rb=%0d f=%b d=%0d required 0 0 0 0 1 0 0",
                  cmd_valid, cmd_write, cmd_addr, wr_bank, rd_bank, frame_fresh, drop_cnt);
      end
      model_init();
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      repeat (3) @(negedge clk);
      wr_level = 10'd16;
      do_burst(0, 1, 1'b0, 1'b0);
      n_checks++;
      if (last_seen_write !== 1'b1 || last_seen_addr !== '0) begin
         n_errors++;
         $display("FAIL stale_done: write=%b addr=%0d required 1 0",
                  last_seen_write, last_seen_addr);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_write();
      test_round_robin();
      test_random();
      test_full_frame();
      test_drop();
      test_events_in_wait();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
